pe_loader: RTL and testbench
============================

# pe_loader

Upstream sequencer for a single `pe`. It accepts one host word stream and issues the PE's instruction-load and data-load phases. Data bursts are re-timed so `din_pe_v` is always contiguous for exactly `DATA_NUM` cycles, which the PE's data-memory counter requires. It paces the configured iterations and drives `alpha_v` for the final one.

## Interface
Parameters:
- `INST_NUM`, 16: instruction words loaded per job.
- `DATA_NUM`, 16: data words per iteration burst (equals `REG_NUM*2`).
- `RUN_CYCLES`, 64: compute-wait cycles after each burst, at least 1.
- `ITER_NUM`, 4: iterations per job, at least 1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  job request, sampled only in IDLE.
- `s_valid`  in  1  host word valid.
- `s_ready`  out  1  loader can accept a word.
- `s_data`  in  `DATA_WIDTH*2`  host word: instruction or packed complex data.
- `inst_in_v`  out  1  instruction write strobe to the PE.
- `inst_in`  out  `INST_WIDTH`  instruction word.
- `din_pe_v`  out  1  data load strobe to the PE.
- `din_pe`  out  `DATA_WIDTH*2`  data word.
- `alpha_v`  out  1  final-iteration flag to the PE.
- `busy`  out  1  a job is in progress.
- `done`  out  1  one-cycle pulse when a job completes.

## Operation
- States: IDLE, LOAD_INST, FILL, BURST, RUN, DONE.
- A transfer occurs on a cycle where `s_valid` and `s_ready` are both 1. `s_data` is ignored on any other cycle.
- IDLE:
  - `s_ready`=0.
  - `start`=1 moves to LOAD_INST, clears all counters and sets `busy`.
- LOAD_INST:
  - `s_ready`=1.
  - Each transfer is registered to `inst_in` with `inst_in_v`=1 on the next cycle.
  - After transfer number `INST_NUM`, move to FILL.
- FILL:
  - `s_ready`=1.
  - Transfers are written in order into a `DATA_NUM`-entry buffer.
  - On the transfer that fills the buffer, move to BURST.
  - No data reaches the PE during FILL.
- BURST:
  - `s_ready`=0.
  - Emit the buffer in FIFO order, one word per cycle, with `din_pe_v`=1 for exactly `DATA_NUM` consecutive cycles.
  - Then move to RUN.
- RUN:
  - `s_ready`=0 and all strobes are 0.
  - Count `RUN_CYCLES` cycles, then increment the iteration counter.
  - If iterations completed equals `ITER_NUM`, go to DONE; otherwise go to FILL.
- DONE: `done`=1 for one cycle, `busy`=0, then IDLE.
- `alpha_v`=1 during the BURST and RUN states of the last iteration, and 0 otherwise. With `ITER_NUM`=1, that is iteration 0.
- `start` while busy is ignored; no queuing.
- Host stalls (`s_valid`=0) in LOAD_INST or FILL only pause progress. Counters hold.
- Counter widths are `$clog2(param+1)`. Counters never wrap within a job and reset to 0 at `start`.

## Timing
- All outputs are registered.
- Reset values:
  - `s_ready`, `inst_in_v`, `din_pe_v`, `alpha_v`, `busy`, `done` are all 0.
  - `inst_in` and `din_pe` are 0.
  - State is IDLE; counters and buffer pointers are 0.
- Data outputs hold 0 when their strobe is 0.
- `start` at cycle T gives `s_ready`=1 at T+1 and `busy`=1 at T+1.
- Instruction transfer at cycle T gives `inst_in_v`=1 with that word at T+1.
- Last FILL transfer at T:
  - `din_pe_v`=1 over T+1 to T+`DATA_NUM`.
  - `s_ready`=0 from T+1.
- RUN occupies the next `RUN_CYCLES` cycles.
- The next FILL raises `s_ready` on the cycle after RUN ends.
- `done` pulses on the cycle after the final RUN cycle.
- Reset mid-job (any state): the next cycle shows all outputs at reset values and no further strobes. Buffered data is discarded.
- `rst` and `start` in the same cycle: reset wins.

## Test plan
- Defaults, 16 instruction words 0x1000_0000+i streamed back-to-back -> 16 consecutive `inst_in_v` pulses carrying matching values, each one cycle after its transfer.
- FILL with `s_valid` toggling every other cycle, data 0xA000+i -> `din_pe_v` high exactly 16 contiguous cycles, words 0xA000..0xA00F in order, nothing emitted before the buffer is full.
- Full job with `ITER_NUM`=4 -> 4 bursts, each followed by 64 idle cycles; `alpha_v` high only during the 4th burst and its RUN; `done` pulses once; `busy` falls with `done`.
- `ITER_NUM`=1, `RUN_CYCLES`=1 -> `alpha_v` high during the single burst and its RUN cycle; `done` two cycles after the last burst word.
- `start` asserted during BURST -> ignored; job completes normally, no second job starts.
- `rst` asserted at the 5th word of a burst -> next cycle `din_pe_v`=0 and all outputs at reset values; a fresh `start` runs a full correct job.

Source files
------------

// File: rtl/pe_loader.sv
// Host-stream sequencer for one PE: loads instructions, then per iteration buffers a
// full data burst so the PE sees a gap-free din_pe_v run, waits RUN_CYCLES, repeats.
module pe_loader #(
  parameter int INST_NUM   = 16,
  parameter int DATA_NUM   = 16,
  parameter int RUN_CYCLES = 64,
  parameter int ITER_NUM   = 4,
  parameter int DATA_WIDTH = 16,
  parameter int INST_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH*2-1:0] s_data,
  output logic                    inst_in_v,
  output logic [INST_WIDTH-1:0]   inst_in,
  output logic                    din_pe_v,
  output logic [DATA_WIDTH*2-1:0] din_pe,
  output logic                    alpha_v,
  output logic                    busy,
  output logic                    done
);
  localparam int WW = DATA_WIDTH * 2;
  localparam int IW = $clog2(INST_NUM + 1);
  localparam int PW = $clog2(DATA_NUM + 1);
  localparam int RW = $clog2(RUN_CYCLES + 1);
  localparam int TW = $clog2(ITER_NUM + 1);
  localparam int AW = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;

  localparam logic [IW-1:0] INST_LAST = IW'(INST_NUM - 1);
  localparam logic [PW-1:0] DATA_LAST = PW'(DATA_NUM - 1);
  localparam logic [PW-1:0] DATA_END  = PW'(DATA_NUM);
  localparam logic [RW-1:0] RUN_LAST  = RW'(RUN_CYCLES - 1);
  localparam logic [TW-1:0] ITER_LAST = TW'(ITER_NUM - 1);

  typedef enum logic [2:0] {IDLE, LOAD_INST, FILL, BURST, RUN, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   inst_cnt;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [RW-1:0]   run_cnt;
  logic [TW-1:0]   iter_cnt;
  logic [WW-1:0]   buf_mem [DATA_NUM];

  logic xfer, last_iter;
  assign xfer      = s_valid && s_ready;
  assign last_iter = (iter_cnt == ITER_LAST);

  // Storage needs no reset: pointers restart at 0 and every entry is rewritten before use.
  always_ff @(posedge clk) begin
    if (state == FILL && xfer) buf_mem[wr_ptr[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      inst_in_v <= 1'b0;
      inst_in   <= '0;
      din_pe_v  <= 1'b0;
      din_pe    <= '0;
      alpha_v   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      inst_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      run_cnt   <= '0;
      iter_cnt  <= '0;
    end else begin
      inst_in_v <= 1'b0;
      inst_in   <= '0;
      din_pe_v  <= 1'b0;
      din_pe    <= '0;
      done      <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= LOAD_INST;
          s_ready  <= 1'b1;
          busy     <= 1'b1;
          inst_cnt <= '0;
          wr_ptr   <= '0;
          rd_ptr   <= '0;
          run_cnt  <= '0;
          iter_cnt <= '0;
        end
        LOAD_INST: if (xfer) begin
          inst_in_v <= 1'b1;
          inst_in   <= s_data[INST_WIDTH-1:0];
          inst_cnt  <= inst_cnt + 1'b1;
          if (inst_cnt == INST_LAST) state <= FILL;
        end
        FILL: if (xfer) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (wr_ptr == DATA_LAST) begin
            // Word 0 goes out on the same edge the final word is written.
            state    <= BURST;
            s_ready  <= 1'b0;
            din_pe_v <= 1'b1;
            din_pe   <= (DATA_NUM == 1) ? s_data : buf_mem[0];
            rd_ptr   <= PW'(1);
            alpha_v  <= last_iter;
          end
        end
        BURST: begin
          if (rd_ptr == DATA_END) begin
            state   <= RUN;
            run_cnt <= '0;
          end else begin
            din_pe_v <= 1'b1;
            din_pe   <= buf_mem[rd_ptr[AW-1:0]];
            rd_ptr   <= rd_ptr + 1'b1;
          end
        end
        RUN: begin
          if (run_cnt == RUN_LAST) begin
            iter_cnt <= iter_cnt + 1'b1;
            alpha_v  <= 1'b0;
            if (last_iter) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state   <= FILL;
              s_ready <= 1'b1;
              wr_ptr  <= '0;
            end
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_loader.sv
// Bench for pe_loader: reset/start vector table, then full jobs on a default instance
// and an ITER_NUM=1/RUN_CYCLES=1 instance, checked cycle by cycle against a job model.
module tb_pe_loader;
  logic        clk = 1'b0;
  logic        rst, start0, start1, s_valid;
  logic [31:0] s_data;
  logic [1:0]  s_ready, inst_in_v, din_pe_v, alpha_v, busy, done;
  logic [31:0] inst_in [2];
  logic [31:0] din_pe  [2];
  int          total = 0, bad = 0, sel = 0;

  always #5 clk = ~clk;

  pe_loader dut0 (
    .clk(clk), .rst(rst), .start(start0), .s_valid(s_valid), .s_ready(s_ready[0]),
    .s_data(s_data), .inst_in_v(inst_in_v[0]), .inst_in(inst_in[0]),
    .din_pe_v(din_pe_v[0]), .din_pe(din_pe[0]), .alpha_v(alpha_v[0]),
    .busy(busy[0]), .done(done[0])
  );

  pe_loader #(.ITER_NUM(1), .RUN_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .s_valid(s_valid), .s_ready(s_ready[1]),
    .s_data(s_data), .inst_in_v(inst_in_v[1]), .inst_in(inst_in[1]),
    .din_pe_v(din_pe_v[1]), .din_pe(din_pe[1]), .alpha_v(alpha_v[1]),
    .busy(busy[1]), .done(done[1])
  );

  typedef struct {
    logic        rst, start, valid;
    logic [31:0] data;
    logic        e_rdy, e_busy, e_iv;
    logic [31:0] e_ii;
  } vec_t;

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic r, input logic iv, input logic [31:0] ii,
                     input logic dv, input logic [31:0] dd, input logic al, input logic b,
                     input logic dn);
    total++;
    if ({s_ready[sel], inst_in_v[sel], inst_in[sel], din_pe_v[sel], din_pe[sel],
         alpha_v[sel], busy[sel], done[sel]} !== {r, iv, ii, dv, dd, al, b, dn}) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got rdy=%b iv=%b ii=%h dv=%b dd=%h a=%b b=%b d=%b want rdy=%b iv=%b ii=%h dv=%b dd=%h a=%b b=%b d=%b",
               nm, sel, $time, s_ready[sel], inst_in_v[sel], inst_in[sel], din_pe_v[sel],
               din_pe[sel], alpha_v[sel], busy[sel], done[sel], r, iv, ii, dv, dd, al, b, dn);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 1) start1 = v; else start0 = v;
  endtask

  // Job model: phases follow directly from the transfer schedule the bench chooses.
  task automatic do_job(input bit stall_inst, input bit toggle_fill, input bit start_in_burst,
                        input int abort_word);
    int          it_n  = (sel == 1) ? 1 : 4;
    int          run_n = (sel == 1) ? 1 : 64;
    logic [31:0] q[$];
    logic [31:0] w;
    logic        v, last;
    int          n, tog;
    set_start(1'b1); step; set_start(1'b0);
    chk("start", 1, 0, 0, 0, 0, 0, 1, 0);
    n = 0;
    while (n < 16) begin
      v = stall_inst ? ($urandom_range(0, 2) != 0) : 1'b1;
      w = 32'h1000_0000 + n;
      s_valid = v; s_data = v ? w : $urandom;
      step; s_valid = 1'b0;
      chk("inst", 1, v, v ? w : 32'h0, 0, 0, 0, 1, 0);
      if (v) n++;
    end
    for (int it = 0; it < it_n; it++) begin
      last = (it == it_n - 1);
      n = 0; tog = 0;
      while (n < 16) begin
        v = toggle_fill ? ((tog % 2) == 0) : ($urandom_range(0, 2) != 0);
        tog++;
        w = 32'hA000 + it * 16 + n;
        s_valid = v; s_data = v ? w : $urandom;
        step; s_valid = 1'b0;
        if (v) begin q.push_back(w); n++; end
        if (n < 16) chk("fill", 1, 0, 0, 0, 0, 0, 1, 0);
        else        chk("burst_first", 0, 0, 0, 1, q.pop_front(), last, 1, 0);
      end
      for (int k = 1; k < 16; k++) begin
        if (start_in_burst && k == 1) set_start(1'b1);
        s_valid = 1'b1; s_data = $urandom;  // not ready: must be ignored
        step; set_start(1'b0); s_valid = 1'b0;
        chk("burst", 0, 0, 0, 1, q.pop_front(), last, 1, 0);
        if (abort_word == k) begin
          rst = 1'b1; step; rst = 1'b0;
          chk("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
          step;
          chk("rst_quiet", 0, 0, 0, 0, 0, 0, 0, 0);
          return;
        end
      end
      for (int r = 0; r < run_n; r++) begin
        step;
        chk("run", 0, 0, 0, 0, 0, last, 1, 0);
      end
      step;
      if (last) chk("done", 0, 0, 0, 0, 0, 0, 0, 1);
      else      chk("refill", 1, 0, 0, 0, 0, 0, 1, 0);
    end
    step;
    chk("idle_after", 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h1000_0000, 1'b1, 1'b1, 1'b1, 32'h1000_0000};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 32'h1000_0001, 1'b1, 1'b1, 1'b1, 32'h1000_0001};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0};
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; s_valid = 1'b0; s_data = '0;
    step; step;
    sel = 0;
    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; start0 = tbl[i].start; s_valid = tbl[i].valid; s_data = tbl[i].data;
      step;
      chk($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_iv, tbl[i].e_ii, 0, 0, 0,
          tbl[i].e_busy, 0);
    end
    rst = 1'b0; start0 = 1'b0; s_valid = 1'b0;
    step;

    // back-to-back instructions, toggling fill, start during burst must be ignored
    sel = 0;
    do_job(1'b0, 1'b1, 1'b1, -1);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("no_rejob", 0, 0, 0, 0, 0, 0, 0, 0);
    end

    sel = 1;
    do_job(1'b1, 1'b0, 1'b0, -1);

    // reset on 5th burst word, then a fresh randomized job
    sel = 0;
    do_job(1'b0, 1'b0, 1'b0, 4);
    do_job(1'b1, 1'b0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
